dram_responder: RTL and testbench



---
 rtl/dram_responder_pkg.sv | 14 +
 rtl/dram_responder_array.sv | 31 +++
 rtl/dram_responder.sv | 173 +++++++++++++++++
 tb/tb_dram_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dram_responder_pkg.sv
// Shared widths and FSM encoding for the data-memory responder.
package dram_responder_pkg;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned DRAM_WAIT_WIDTH = 4;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'd0,
    DRAM_WAIT = 2'd1,
    DRAM_RESP = 2'd2
  } dram_state_e;

endpackage

// File: rtl/dram_responder_array.sv
// Synchronous single-port word array: per-byte write enables, registered read.
module dram_array
  import dram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [3:0]            be_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dram_responder.sv
// Data-memory responder with programmable wait states and range checking.
// Optional byte-lane writes are enabled with `define DRAM_BYTE_WRITE_EN.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int unsigned         DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned         WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ram_req_i,
  input  logic                  ram_w_request_i,
  input  logic [ADDR_WIDTH-1:0] ram_addr_i,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
`ifdef DRAM_BYTE_WRITE_EN
  input  logic [3:0]            ram_be_i,
`endif
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  data_ready_o,
  output logic                  ram_err_o,
  output logic                  busy_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] END_ADDR =
    {1'b0, BASE_ADDR} + ({1'b0, ADDR_WIDTH'(DEPTH_WORDS)} << 2);
  localparam logic [DRAM_WAIT_WIDTH-1:0] WAIT_LOAD = DRAM_WAIT_WIDTH'(WAIT_CYCLES);

  dram_state_e                state_q, state_d;
  logic [DRAM_WAIT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       we_q, we_d;
  logic                       inr_q, inr_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [3:0]                 be_q, be_d;
  logic                       ready_q, ready_d;
  logic                       err_q, err_d;
  logic                       has_rd_q, has_rd_d;
  logic                       rd_err_q, rd_err_d;

  logic                       in_range;
  logic [3:0]                 be_in;
  logic                       fire;
  logic                       acc_we, acc_inr;
  logic [IDX_W-1:0]           acc_idx;
  logic [DATA_WIDTH-1:0]      acc_wdata;
  logic [3:0]                 acc_be;
  logic                       mem_we, mem_re;
  logic [DATA_WIDTH-1:0]      mem_rdata;

`ifdef DRAM_BYTE_WRITE_EN
  assign be_in = ram_be_i;
`else
  assign be_in = '1;
`endif

  assign in_range = (ram_addr_i >= BASE_ADDR) && ({1'b0, ram_addr_i} < END_ADDR);

  // With zero wait states the array fires on the accepting edge, before the
  // latched copies exist, so the access fields come straight from the inputs.
  always_comb begin
    if (state_q == DRAM_IDLE) begin
      acc_we    = ram_w_request_i;
      acc_inr   = in_range;
      acc_idx   = ram_addr_i[IDX_W+1:2];
      acc_wdata = ram_data_i;
      acc_be    = be_in;
    end else begin
      acc_we    = we_q;
      acc_inr   = inr_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    inr_d   = inr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    fire    = 1'b0;
    unique case (state_q)
      DRAM_IDLE: begin
        if (ram_req_i) begin
          we_d    = ram_w_request_i;
          inr_d   = in_range;
          idx_d   = ram_addr_i[IDX_W+1:2];
          wdata_d = ram_data_i;
          be_d    = be_in;
          cnt_d   = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d = DRAM_RESP;
            fire    = 1'b1;
          end else begin
            state_d = DRAM_WAIT;
          end
        end
      end
      DRAM_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DRAM_WAIT_WIDTH'(1)) begin
          state_d = DRAM_RESP;
          fire    = 1'b1;
        end
      end
      DRAM_RESP: state_d = DRAM_IDLE;
      default:   state_d = DRAM_IDLE;
    endcase
  end

  always_comb begin
    ready_d  = fire;
    err_d    = fire & ~acc_inr;
    has_rd_d = has_rd_q | (fire & ~acc_we);
    rd_err_d = (fire & ~acc_we) ? ~acc_inr : rd_err_q;
  end

  // The array has no reset, so its strobes are held off while reset is low.
  assign mem_we = fire &  acc_we & acc_inr & rst_n_i;
  assign mem_re = fire & ~acc_we & acc_inr & rst_n_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= DRAM_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      inr_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      has_rd_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      inr_q    <= inr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      has_rd_q <= has_rd_d;
      rd_err_q <= rd_err_d;
    end
  end

  dram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .be_i    (acc_be),
    .idx_i   (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (mem_rdata)
  );

  // Read data is zero after reset and after an out-of-range read.
  assign ram_data_o   = (has_rd_q && !rd_err_q) ? mem_rdata : '0;
  assign data_ready_o = ready_q;
  assign ram_err_o    = err_q;
  assign busy_o       = (state_q != DRAM_IDLE);

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: instance 0 has 2 wait states, instance 1 none.
module tb_dram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        ready_s [2];
  logic        err_s   [2];
  logic        busy_s  [2];
`ifdef DRAM_BYTE_WRITE_EN
  logic [3:0]  be_s    [2];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dram_responder #(.WAIT_CYCLES(2)) dut_w2 (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .ram_req_i       (req_s[0]),
    .ram_w_request_i (we_s[0]),
    .ram_addr_i      (addr_s[0]),
    .ram_data_i      (wdata_s[0]),
`ifdef DRAM_BYTE_WRITE_EN
    .ram_be_i        (be_s[0]),
`endif
    .ram_data_o      (rdata_s[0]),
    .data_ready_o    (ready_s[0]),
    .ram_err_o       (err_s[0]),
    .busy_o          (busy_s[0])
  );

  dram_responder #(.WAIT_CYCLES(0)) dut_w0 (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .ram_req_i       (req_s[1]),
    .ram_w_request_i (we_s[1]),
    .ram_addr_i      (addr_s[1]),
    .ram_data_i      (wdata_s[1]),
`ifdef DRAM_BYTE_WRITE_EN
    .ram_be_i        (be_s[1]),
`endif
    .ram_data_o      (rdata_s[1]),
    .data_ready_o    (ready_s[1]),
    .ram_err_o       (err_s[1]),
    .busy_o          (busy_s[1])
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on instance s; returns to the IDLE cycle after the pulse.
  task automatic access(input int s, input bit we, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rd,
                        output logic er, output int lat);
    req_s[s] = 1'b1; we_s[s] = we; addr_s[s] = addr; wdata_s[s] = data;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!ready_s[s] && lat < 20) chk("busy_while_waiting", 32'(busy_s[s]), 32'd1);
    end while (!ready_s[s] && lat < 20);
    rd = rdata_s[s];
    er = err_s[s];
    req_s[s] = 1'b0;
    @(posedge clk); #1;
    chk("pulse_one_cycle", 32'(ready_s[s]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0,         1'b0};
    tbl[4]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 32'h0,         1'b1};
    tbl[5]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
    tbl[6]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,         1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0,         1'b0};
    tbl[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5_A5A5, 1'b0};
    tbl[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};

    for (int s = 0; s < 2; s++) begin
      req_s[s] = 1'b0; we_s[s] = 1'b0; addr_s[s] = '0; wdata_s[s] = '0;
`ifdef DRAM_BYTE_WRITE_EN
      be_s[s] = 4'hF;
`endif
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready_s[0]), 32'd0);
    chk("reset_err",   32'(err_s[0]),   32'd0);
    chk("reset_busy",  32'(busy_s[0]),  32'd0);
    chk("reset_data",  rdata_s[0],      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      access(0, tbl[i].we, tbl[i].addr, tbl[i].data, rd, er, lat);
      chk($sformatf("latency[%0d]", i), 32'(lat), 32'd3);
      chk($sformatf("err[%0d]", i), 32'(er), 32'(tbl[i].exp_err));
      if (!tbl[i].we) chk($sformatf("rdata[%0d]", i), rd, tbl[i].exp_rd);
    end

    // Read data holds after the pulse.
    access(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("hold_first", rd, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_later", rdata_s[0], 32'hDEAD_BEEF);

    // Zero wait states, request held across back-to-back reads.
    access(1, 1'b1, 32'h0, 32'h0101_0101, rd, er, lat);
    chk("w0_wr_latency_a", 32'(lat), 32'd1);
    access(1, 1'b1, 32'h4, 32'h0202_0202, rd, er, lat);
    chk("w0_wr_latency_b", 32'(lat), 32'd1);
    req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h0;
    @(posedge clk); #1;
    chk("w0_pulse1",  32'(ready_s[1]), 32'd1);
    chk("w0_data1",   rdata_s[1],      32'h0101_0101);
    addr_s[1] = 32'h4;
    @(posedge clk); #1;
    chk("w0_gap",     32'(ready_s[1]), 32'd0);
    chk("w0_gap_busy", 32'(busy_s[1]), 32'd0);
    @(posedge clk); #1;
    chk("w0_pulse2",  32'(ready_s[1]), 32'd1);
    chk("w0_data2",   rdata_s[1],      32'h0202_0202);
    req_s[1] = 1'b0;
    @(posedge clk); #1;
    chk("w0_idle",    32'(ready_s[1]), 32'd0);

    // Reset during the wait phase of a write drops the write.
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h9999_9999;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy_s[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready_s[0]), 32'd0);
    chk("mid_rst_busy",  32'(busy_s[0]),  32'd0);
    chk("mid_rst_data",  rdata_s[0],      32'd0);
    req_s[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_no_pulse", 32'(ready_s[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("after_rst_latency", 32'(lat), 32'd3);
    chk("after_rst_data", rd, 32'hCAFE_F00D);

`ifdef DRAM_BYTE_WRITE_EN
    be_s[0] = 4'hF;
    access(0, 1'b1, 32'h40, 32'h1122_3344, rd, er, lat);
    be_s[0] = 4'b0101;
    access(0, 1'b1, 32'h40, 32'hAABB_CCDD, rd, er, lat);
    be_s[0] = 4'hF;
    access(0, 1'b0, 32'h40, 32'h0, rd, er, lat);
    chk("be_0101_data", rd, 32'h11BB_33DD);
    be_s[0] = 4'b0000;
    access(0, 1'b1, 32'h40, 32'hFFFF_FFFF, rd, er, lat);
    chk("be_0000_latency", 32'(lat), 32'd3);
    chk("be_0000_err", 32'(er), 32'd0);
    be_s[0] = 4'hF;
    access(0, 1'b0, 32'h40, 32'h0, rd, er, lat);
    chk("be_0000_data", rd, 32'h11BB_33DD);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
